// File: rtl/riscv_pkg.sv
// Shared RISC-V load definitions: load op encoding, load FSM states and
// small helpers that map a load op to its access size and extension kind.
package riscv_pkg;

  typedef enum logic [2:0] {
    LOAD_OP_LB,
    LOAD_OP_LH,
    LOAD_OP_LW,
    LOAD_OP_LBU,
    LOAD_OP_LHU,
    LOAD_OP_LD,
    LOAD_OP_LWU,
    LOAD_OP_ILLEGAL
  } LoadOp_t;

  typedef enum logic [1:0] {
    IDLE,
    RD0,
    RD1,
    RESP
  } LoadState_t;

  // funct3 -> load op; LD/LWU exist only on a 64-bit datapath.
  function automatic LoadOp_t load_decode(input logic [2:0] funct3, input logic rv64);
    LoadOp_t op;
    op = LOAD_OP_ILLEGAL;
    case (funct3)
      3'b000: op = LOAD_OP_LB;
      3'b001: op = LOAD_OP_LH;
      3'b010: op = LOAD_OP_LW;
      3'b011: op = rv64 ? LOAD_OP_LD : LOAD_OP_ILLEGAL;
      3'b100: op = LOAD_OP_LBU;
      3'b101: op = LOAD_OP_LHU;
      3'b110: op = rv64 ? LOAD_OP_LWU : LOAD_OP_ILLEGAL;
      default: op = LOAD_OP_ILLEGAL;
    endcase
    return op;
  endfunction

  // Access size in bytes; 0 for an illegal op.
  function automatic logic [3:0] load_size(input LoadOp_t op);
    logic [3:0] sz;
    case (op)
      LOAD_OP_LB, LOAD_OP_LBU: sz = 4'd1;
      LOAD_OP_LH, LOAD_OP_LHU: sz = 4'd2;
      LOAD_OP_LW, LOAD_OP_LWU: sz = 4'd4;
      LOAD_OP_LD:              sz = 4'd8;
      default:                 sz = 4'd0;
    endcase
    return sz;
  endfunction

  // Signed loads replicate the top loaded bit; unsigned loads fill with zero.
  function automatic logic load_signed(input LoadOp_t op);
    return (op == LOAD_OP_LB) || (op == LOAD_OP_LH) ||
           (op == LOAD_OP_LW) || (op == LOAD_OP_LD);
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load alignment: shifts the two-beat window {beat1,beat0}
// down by the byte offset, keeps the op's size and sign/zero extends it.
module load_align_ext
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFS_W = 2
) (
  input  LoadOp_t           op,
  input  logic [OFS_W-1:0]  ofs,
  input  logic [XLEN-1:0]   beat0,
  input  logic [XLEN-1:0]   beat1,
  output logic [XLEN-1:0]   data
);

  logic [2*XLEN-1:0] pair;
  logic [XLEN-1:0]   low;
  int                nbits;
  logic              sign;

  // Byte-shift the window, then keep nbits and fill the rest with the sign.
  always_comb begin
    pair = {beat1, beat0};
    low  = '0;
    for (int i = 0; i < XLEN; i++) begin
      low[i] = pair[i + 8 * int'(ofs)];
    end
    nbits = 8 * int'(load_size(op));
    if (nbits > XLEN) nbits = XLEN;
    sign = 1'b0;
    if (load_signed(op) && (nbits != 0)) sign = low[nbits-1];
    data = '0;
    for (int i = 0; i < XLEN; i++) begin
      data[i] = (i < nbits) ? low[i] : sign;
    end
  end

endmodule

// File: rtl/load_unit.sv
// Load unit between the LSU issue stage and the data-memory port.
// Accepts a load in IDLE, issues one (or, for a word-crossing access, two)
// aligned word reads, then holds the extended result until consumed.
// Optional feature macro: LOAD_UNIT_MISALIGNED_SPLIT_EN -- when defined any
// alignment is legal and word-crossing loads take a second read beat (RD1);
// when undefined, addr % size != 0 faults without touching memory.
//
// Handshakes: every channel uses valid/ready; a transfer happens on a rising
// edge where both are high, and a valid side keeps its payload stable until
// that edge (mem_ready_i is a completion strobe sampled only in RD0/RD1).
module load_unit
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_fault_o,
  output LoadState_t        dbg_state_o
);

  localparam int   WORD  = XLEN / 8;
  localparam int   OFS_W = $clog2(WORD);
  localparam logic RV64  = (XLEN == 64);

  LoadState_t        state, state_next;
  LoadOp_t           op_q, req_op;
  logic [ADDR_W-1:0] addr_q, base_addr;
  logic [XLEN-1:0]   beat0_q, rsp_data_q;
  logic [XLEN-1:0]   align_beat0, align_beat1, align_data;
  logic              rsp_fault_q, req_fault;

`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
  logic [XLEN-1:0]   beat1_q;
  logic              crossing;
  assign crossing = (int'(addr_q[OFS_W-1:0]) + int'(load_size(op_q))) > WORD;
`endif

  assign base_addr   = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign rsp_data_o  = rsp_data_q;
  assign rsp_fault_o = rsp_fault_q;
  assign dbg_state_o = state;

  // Decode the incoming request and decide whether it faults up front.
  always_comb begin
    req_op    = load_decode(req_funct3_i, RV64);
    req_fault = (req_op == LOAD_OP_ILLEGAL);
`ifndef LOAD_UNIT_MISALIGNED_SPLIT_EN
    if ((int'(req_addr_i[OFS_W-1:0]) & (int'(load_size(req_op)) - 1)) != 0) req_fault = 1'b1;
`endif
  end

  // The beat arriving this cycle bypasses its register so the result can be
  // captured on the same edge that completes the last read.
  always_comb begin
    align_beat0 = (state == RD0) ? mem_rdata_i : beat0_q;
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
    align_beat1 = (state == RD1) ? mem_rdata_i : beat1_q;
`else
    align_beat1 = '0;
`endif
  end

  load_align_ext #(
    .XLEN  (XLEN),
    .OFS_W (OFS_W)
  ) u_align (
    .op    (op_q),
    .ofs   (addr_q[OFS_W-1:0]),
    .beat0 (align_beat0),
    .beat1 (align_beat1),
    .data  (align_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = req_fault ? RESP : RD0;
      end
      RD0: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = base_addr;
        if (mem_ready_i) begin
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
          state_next = crossing ? RD1 : RESP;
`else
          state_next = RESP;
`endif
        end
      end
      RD1: begin
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
        mem_valid_o = 1'b1;
        mem_addr_o  = base_addr + ADDR_W'(WORD);
        if (mem_ready_i) state_next = RESP;
`else
        state_next = IDLE;
`endif
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, read beats and response registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q        <= LOAD_OP_LB;
      addr_q      <= '0;
      beat0_q     <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      if ((state == IDLE) && req_valid_i) begin
        op_q        <= req_op;
        addr_q      <= req_addr_i;
        rsp_fault_q <= req_fault;
        rsp_data_q  <= '0;
      end
      if ((state == RD0) && mem_ready_i) beat0_q <= mem_rdata_i;
      if (((state == RD0) || (state == RD1)) && (state_next == RESP)) rsp_data_q <= align_data;
    end
  end

`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
  // Second beat of a word-crossing load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          beat1_q <= '0;
    else if ((state == RD1) && mem_ready_i) beat1_q <= mem_rdata_i;
  end
`endif

endmodule
